// File: rtl/pong_enq_arbiter.sv
// ============================================================================
// Module  : pong_enq_arbiter
// Brief   : Round-robin, burst-bounded arbiter for two producers sharing one
//           ping-pong buffer enq port; keeps per-source transfer counts.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pong_enq_arbiter #(
    parameter int WIDTH = 704,
    parameter int BURST = 4,
    parameter int CW    = 3
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             i_in0_want,
    input  logic             i_in0_enq_ena,
    input  logic [WIDTH-1:0] i_in0_enq_v,
    output logic             o_in0_enq_rdy,
    input  logic             i_in1_want,
    input  logic             i_in1_enq_ena,
    input  logic [WIDTH-1:0] i_in1_enq_v,
    output logic             o_in1_enq_rdy,
    output logic             o_out_enq_ena,
    output logic [WIDTH-1:0] o_out_enq_v,
    output logic             o_out_enq_src,
    input  logic             i_out_enq_rdy,
    output logic [31:0]      o_count0,
    output logic [31:0]      o_count1
);

    localparam logic [CW-1:0] c_BURST = CW'(BURST);
    localparam logic [CW-1:0] c_ONE   = CW'(1);

    logic          r_prio;
    logic          r_last_src;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_count0;
    logic [31:0]   r_count1;

    logic          w_gv;
    logic          w_sel;
    logic          w_fire0;
    logic          w_fire1;
    logic          w_fire;
    logic          w_src;
    logic          w_other_want;
    logic [CW-1:0] w_cnt_n;

    // prio only matters under contention; a lone requester always wins
    assign w_gv    = i_in0_want | i_in1_want;
    assign w_sel   = (i_in0_want & i_in1_want) ? r_prio : i_in1_want;

    assign o_in0_enq_rdy = nRST & i_out_enq_rdy & w_gv & ~w_sel;
    assign o_in1_enq_rdy = nRST & i_out_enq_rdy & w_gv &  w_sel;

    assign w_fire0 = i_in0_enq_ena & o_in0_enq_rdy;
    assign w_fire1 = i_in1_enq_ena & o_in1_enq_rdy;
    assign w_fire  = w_fire0 | w_fire1;
    assign w_src   = w_fire1;
    assign w_other_want = w_src ? i_in0_want : i_in1_want;

    assign o_out_enq_ena = w_fire;
    assign o_out_enq_src = nRST & w_sel;
    assign o_out_enq_v   = w_fire0 ? i_in0_enq_v : (w_fire1 ? i_in1_enq_v : '0);

    always_comb begin
        w_cnt_n = c_ONE;
        if (w_src == r_last_src) begin
            w_cnt_n = (r_cnt >= c_BURST) ? c_BURST : r_cnt + c_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_prio     <= 1'b0;
            r_last_src <= 1'b0;
            r_cnt      <= '0;
            r_count0   <= '0;
            r_count1   <= '0;
        end else if (w_fire) begin
            r_last_src <= w_src;
            if (w_src) r_count1 <= r_count1 + 32'd1;
            else       r_count0 <= r_count0 + 32'd1;
            // hand over only when the other side is actually waiting
            if (w_other_want && (w_cnt_n == c_BURST)) begin
                r_prio <= ~w_src;
                r_cnt  <= '0;
            end else begin
                r_cnt  <= w_cnt_n;
            end
        end
    end

    assign o_count0 = r_count0;
    assign o_count1 = r_count1;

    a_grant_exclusive: assert property (@(posedge CLK) !(o_in0_enq_rdy && o_in1_enq_rdy));
    a_fire_needs_rdy:  assert property (@(posedge CLK) o_out_enq_ena |-> i_out_enq_rdy);

endmodule

`default_nettype wire

// File: tb/tb_pong_enq_arbiter.sv
// ============================================================================
// Module  : tb_pong_enq_arbiter
// Brief   : Self-checking bench for pong_enq_arbiter against a streak-count model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pong_enq_arbiter;

    localparam int WIDTH = 704;
    localparam int BURST = 4;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             want0, ena0, want1, ena1, ordy;
    logic [WIDTH-1:0] v0, v1;
    logic             rdy0, rdy1, oena, osrc;
    logic [WIDTH-1:0] ov;
    logic [31:0]      cnt0, cnt1;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: the current source's unbroken grant streak
    bit          m_prio;
    bit          m_last;
    int          m_streak;
    bit [31:0]   m_cnt0, m_cnt1;
    bit          fires[$];

    always #5 CLK = ~CLK;

    pong_enq_arbiter #(.WIDTH(WIDTH), .BURST(BURST), .CW(3)) dut (
        .CLK(CLK), .nRST(nRST),
        .i_in0_want(want0), .i_in0_enq_ena(ena0), .i_in0_enq_v(v0), .o_in0_enq_rdy(rdy0),
        .i_in1_want(want1), .i_in1_enq_ena(ena1), .i_in1_enq_v(v1), .o_in1_enq_rdy(rdy1),
        .o_out_enq_ena(oena), .o_out_enq_v(ov), .o_out_enq_src(osrc), .i_out_enq_rdy(ordy),
        .o_count0(cnt0), .o_count1(cnt1)
    );

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_payload();
        logic [WIDTH-1:0] p;
        for (int i = 0; i < WIDTH; i += 32) p[i +: 32] = $urandom;
        return p;
    endfunction

    task automatic step(input bit w0, input bit e0, input bit w1, input bit e1,
                        input bit r, input bit rstn);
        bit sel, e_rdy0, e_rdy1, f0, f1, other;
        logic [WIDTH-1:0] e_v;
        want0 = w0; ena0 = e0; want1 = w1; ena1 = e1; ordy = r; nRST = rstn;
        v0 = rand_payload(); v1 = rand_payload();
        @(negedge CLK);
        sel    = (w0 && w1) ? m_prio : w1;
        e_rdy0 = rstn && r && (w0 || w1) && !sel;
        e_rdy1 = rstn && r && (w0 || w1) &&  sel;
        f0     = e0 && e_rdy0;
        f1     = e1 && e_rdy1;
        e_v    = f0 ? v0 : (f1 ? v1 : '0);
        check("rdy0", rdy0, e_rdy0);
        check("rdy1", rdy1, e_rdy1);
        check("out_ena", oena, f0 || f1);
        check("out_v", ov, e_v);
        check("out_src", osrc, rstn && sel);
        check("count0", cnt0, m_cnt0);
        check("count1", cnt1, m_cnt1);
        if (!rstn) begin
            m_prio = 0; m_last = 0; m_streak = 0; m_cnt0 = 0; m_cnt1 = 0;
        end else if (f0 || f1) begin
            fires.push_back(f1);
            m_streak = (m_last == f1) ? m_streak + 1 : 1;
            m_last   = f1;
            if (f1) m_cnt1++; else m_cnt0++;
            other = f1 ? w0 : w1;
            if (other && m_streak >= BURST) begin
                m_prio   = !f1;
                m_streak = 0;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [15:0] pattern(input int n);
        logic [15:0] p = '0;
        for (int i = 0; i < n && i < fires.size(); i++) p = {p[14:0], fires[i]};
        return p;
    endfunction

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) step(1, 1, 1, 1, 1, 0);
    endtask

    initial begin
        want0 = 0; ena0 = 0; want1 = 0; ena1 = 0; ordy = 1; nRST = 0; v0 = '0; v1 = '0;
        @(posedge CLK); #1;

        // reset with both wanting, then release
        do_reset(3);
        step(1, 0, 1, 0, 1, 1);
        check("reset_rdy0", rdy0, 1'b1);
        check("reset_count0", cnt0, 32'd0);

        // solo stream from source 0
        do_reset(2);
        fires.delete();
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 1, 1);
        check("solo_count0", cnt0, 32'd10);
        check("solo_pattern", pattern(10), 16'h0000);
        check("solo_nfires", fires.size(), 10);

        // contention, BURST=4
        do_reset(2);
        fires.delete();
        for (int i = 0; i < 40 && fires.size() < 12; i++) step(1, 1, 1, 1, 1, 1);
        check("contend_pattern", pattern(12), 16'b0000_1111_0000);
        check("contend_nfires", fires.size(), 12);

        // contention with buffer backpressure on cycles 3-5
        do_reset(2);
        fires.delete();
        for (int i = 0; i < 40 && fires.size() < 12; i++)
            step(1, 1, 1, 1, !(i >= 3 && i <= 5), 1);
        check("bp_pattern", pattern(12), 16'b0000_1111_0000);

        // ENA from requester 1 while it is not granted
        do_reset(2);
        step(1, 0, 1, 1, 1, 1);
        check("drop_ena", oena, 1'b0);
        check("drop_count1", cnt1, 32'd0);

        // late arrival of requester 1
        do_reset(2);
        fires.delete();
        step(1, 1, 0, 0, 1, 1);
        step(1, 1, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 1, 1);
        check("late_pattern", pattern(5), 16'b00001);

        // randomized traffic with occasional reset
        do_reset(2);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 4) != 0, $urandom_range(0, 199) != 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
